// File: rtl/player_cond_unit.sv
// Per-frame player pose conditioner: latches the requested pose, probes the wall map
// for the full move and both single-axis slides, then commits a legal pose and wraps the angle.
module player_cond_unit #(
    parameter int unsigned MAP_W      = 16,
    parameter int unsigned MAP_H      = 16,
    parameter int unsigned CELL_SHIFT = 6,
    parameter int unsigned ANGLE_MAX  = 360,
    parameter logic [31:0] INIT_X     = 32'h0000_0060,
    parameter logic [31:0] INIT_Y     = 32'h0000_0060
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [31:0] req_a,
    output logic [7:0]  map_addr,
    input  logic        map_data,
    output logic [31:0] cond_x,
    output logic [31:0] cond_y,
    output logic [31:0] cond_a,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, RD_XY, RD_X, RD_Y, DECIDE} state_t;

    state_t      state;
    logic [31:0] rx, ry, ra;
    logic        w_xy, w_x, wall_y;

    function automatic logic [7:0] cell_addr(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] cx, cy, a;
        cx = x >> CELL_SHIFT;
        cy = y >> CELL_SHIFT;
        a  = {28'd0, cy[3:0]} * MAP_W + {28'd0, cx[3:0]};
        return a[7:0];
    endfunction

    function automatic logic cell_oob(input logic [31:0] x, input logic [31:0] y);
        return ((x >> CELL_SHIFT) >= MAP_W) || ((y >> CELL_SHIFT) >= MAP_H);
    endfunction

    // ROM data arrives one cycle after its address, so each capture re-derives
    // the out-of-bounds flag of the address issued in the previous state.
    always_comb begin
        wall_y = map_data | cell_oob(cond_x, ry);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cond_x   <= INIT_X;
            cond_y   <= INIT_Y;
            cond_a   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            map_addr <= '0;
            rx       <= '0;
            ry       <= '0;
            ra       <= '0;
            w_xy     <= 1'b0;
            w_x      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        rx       <= req_x;
                        ry       <= req_y;
                        ra       <= req_a;
                        map_addr <= cell_addr(req_x, req_y);
                        busy     <= 1'b1;
                        state    <= RD_XY;
                    end
                end
                RD_XY: begin
                    map_addr <= cell_addr(rx, cond_y);
                    state    <= RD_X;
                end
                RD_X: begin
                    w_xy     <= map_data | cell_oob(rx, ry);
                    map_addr <= cell_addr(cond_x, ry);
                    state    <= RD_Y;
                end
                RD_Y: begin
                    w_x   <= map_data | cell_oob(rx, cond_y);
                    state <= DECIDE;
                end
                DECIDE: begin
                    if (!w_xy) begin
                        cond_x <= rx;
                        cond_y <= ry;
                    end else if (!w_x) begin
                        cond_x <= rx;
                    end else if (!wall_y) begin
                        cond_y <= ry;
                    end
                    cond_a <= (ra >= ANGLE_MAX) ? ra - ANGLE_MAX : ra;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
